pswd_enroll_writer: RTL and testbench

- Write side of the password store: enrolls new 4-bit passwords into the dual-port password RAM that the authentication reader scans.
- Sequence: a logged-in user enters a candidate, confirms it by entering it again, and the block checks the table for a duplicate before appending the entry at the next free address.
- Sits beside the access controller and shares the RAM: read port for the duplicate scan, write port for the append.

---
 rtl/access_pkg.sv | 17 +
 rtl/pswd_enroll_writer_btn_edge_detect.sv | 21 ++
 rtl/pswd_enroll_writer.sv | 177 +++++++++++++++++
 tb/tb_pswd_enroll_writer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/access_pkg.sv
// Shared definitions for the password store: field widths and the enrollment FSM state encoding.
package access_pkg;

  localparam int PSWD_W        = 4;
  localparam int ADDR_W        = 5;
  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CONFIRM,
    SCAN_REQ,
    SCAN_CHK,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/pswd_enroll_writer_btn_edge_detect.sv
// One-register rising-edge detector: a single-cycle pulse for each 0->1 transition of a button level.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_btn;
    end
  end

  assign o_pulse = i_btn & ~r_prev;

endmodule

// File: rtl/pswd_enroll_writer.sv
// Password enrollment writer: enter, confirm, scan the table for a duplicate, then append.
// Optional confirm timeout is compiled in with `define PSWD_ENROLL_TIMEOUT_EN.
module pswd_enroll_writer
  import access_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = 1000,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Enroll_Enter,
  input  logic [PSWD_W-1:0] Password,
  input  logic              Logged_In,
  output logic [AW-1:0]     rd_addr,
  input  logic [PSWD_W-1:0] rd_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [PSWD_W-1:0] wr_data,
  output logic [CW-1:0]     Count,
  output logic              Busy,
  output logic              Full,
  output logic              Enrolled,
  output logic              Rejected,
  output state_t            o_dbg_state
);

  logic              w_edge;
  state_t            r_state;
  state_t            w_next;
  logic [PSWD_W-1:0] r_cand;
  logic [AW-1:0]     r_idx;
  logic [CW-1:0]     r_count;
  logic              r_rejected;

  logic w_full;
  logic w_last;
  logic w_reject;
  logic w_latch;
  logic w_scan_start;
  logic w_idx_inc;
  logic w_cnt_inc;
  logic w_tmo_hit;

  btn_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (Enroll_Enter),
    .o_pulse (w_edge)
  );

  assign w_full = (r_count == CW'(DEPTH));
  assign w_last = (CW'(r_idx) == r_count - CW'(1));

`ifdef PSWD_ENROLL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_tmo;

  // Free-runs only while waiting for the confirm; any other state holds it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (r_state != WAIT_CONFIRM) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_reject     = 1'b0;
    w_latch      = 1'b0;
    w_scan_start = 1'b0;
    w_idx_inc    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          if (!Logged_In || w_full) begin
            w_reject = 1'b1;
          end else begin
            w_latch = 1'b1;
            w_next  = WAIT_CONFIRM;
          end
        end
      end
      WAIT_CONFIRM: begin
        if (!Logged_In) begin
          w_reject = 1'b1;
          w_next   = IDLE;
        end else if (w_edge) begin
          if (Password != r_cand) begin
            w_reject = 1'b1;
            w_next   = IDLE;
          end else if (r_count == '0) begin
            w_next = WRITE;
          end else begin
            w_scan_start = 1'b1;
            w_next       = SCAN_REQ;
          end
        end else if (w_tmo_hit) begin
          w_reject = 1'b1;
          w_next   = IDLE;
        end
      end
      SCAN_REQ: w_next = SCAN_CHK;
      // rd_data here answers the address presented during SCAN_REQ.
      SCAN_CHK: begin
        if (rd_data == r_cand) begin
          w_reject = 1'b1;
          w_next   = IDLE;
        end else if (w_last) begin
          w_next = WRITE;
        end else begin
          w_idx_inc = 1'b1;
          w_next    = SCAN_REQ;
        end
      end
      WRITE: begin
        w_cnt_inc = 1'b1;
        w_next    = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_rejected <= 1'b0;
    end else begin
      r_rejected <= w_reject;
      if (w_latch) begin
        r_cand <= Password;
      end
      if (w_scan_start) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + AW'(1);
      end
      if (w_cnt_inc) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // WRITE is only reachable with Count < DEPTH, so the write address never overflows.
  assign wr_en       = (r_state == WRITE);
  assign wr_addr     = wr_en ? r_count[AW-1:0] : '0;
  assign wr_data     = wr_en ? r_cand : '0;
  assign rd_addr     = r_idx;
  assign Count       = r_count;
  assign Busy        = (r_state != IDLE);
  assign Full        = w_full;
  assign Enrolled    = (r_state == DONE);
  assign Rejected    = r_rejected;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pswd_enroll_writer.sv
// Bench for pswd_enroll_writer: 32-entry instance with a RAM model and scoreboard, plus a 4-entry instance for Full.
module tb_pswd_enroll_writer;
  import access_pkg::*;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [3:0] pw;
  logic       login;
  logic [4:0] rd_addr;
  logic [3:0] rd_data;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic [5:0] count;
  logic       busy, full, enrolled, rejected;
  state_t     dbg;

  logic       e4_enter;
  logic [3:0] e4_pw;
  logic       e4_login;
  logic [1:0] rd_addr4;
  logic [3:0] rd_data4;
  logic       wr_en4;
  logic [1:0] wr_addr4;
  logic [3:0] wr_data4;
  logic [2:0] count4;
  logic       busy4, full4, enrolled4, rejected4;
  state_t     dbg4;

  logic [3:0] mem[32];
  logic [3:0] mem4[4];

  logic [8:0] exp_wr_q[$];
  logic [1:0] exp_ev_q[$];
  logic [3:0] tbl[$];
  logic [4:0] rd_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_enr4   = 0;
  int n_rej4   = 0;
  int n_wr4    = 0;
  bit busy_seen = 0;
  bit busy4_seen = 0;

  pswd_enroll_writer #(.DEPTH(32), .TIMEOUT(1000)) u_dut (
    .clk(clk), .rst(rst), .Enroll_Enter(enter), .Password(pw), .Logged_In(login),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .Count(count), .Busy(busy), .Full(full), .Enrolled(enrolled), .Rejected(rejected),
    .o_dbg_state(dbg)
  );

  pswd_enroll_writer #(.DEPTH(4), .TIMEOUT(1000)) u_dut4 (
    .clk(clk), .rst(rst), .Enroll_Enter(e4_enter), .Password(e4_pw), .Logged_In(e4_login),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .Count(count4), .Busy(busy4), .Full(full4), .Enrolled(enrolled4), .Rejected(rejected4),
    .o_dbg_state(dbg4)
  );

  // clock / reset / RAM models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    foreach (mem[i]) mem[i] = 4'h0;
    foreach (mem4[i]) mem4[i] = 4'h0;
  end

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
    if (wr_en4) mem4[wr_addr4] <= wr_data4;
    rd_data4 <= mem4[rd_addr4];
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          $display("FAIL unexpected_write got addr=%0d data=%h required no write", wr_addr, wr_data);
        end else begin
          logic [8:0] e;
          e = exp_wr_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                     wr_addr, wr_data, e[8:4], e[3:0]);
          else n_pass++;
        end
      end
      if (enrolled || rejected) begin
        n_checks++;
        if (exp_ev_q.size() == 0) begin
          $display("FAIL unexpected_event got enr=%0b rej=%0b required none", enrolled, rejected);
        end else begin
          logic [1:0] e;
          e = exp_ev_q.pop_front();
          if ({rejected, enrolled} !== e)
            $display("FAIL event got {rej,enr}=%b required %b", {rejected, enrolled}, e);
          else n_pass++;
        end
      end
      if (dbg == SCAN_REQ) rd_log.push_back(rd_addr);
      if (busy) busy_seen = 1;
      if (busy4) busy4_seen = 1;
      if (enrolled4) n_enr4++;
      if (rejected4) n_rej4++;
      if (wr_en4) n_wr4++;
    end
  end

  // driver tasks
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit sel, input logic [3:0] v);
    @(negedge clk);
    if (sel) begin e4_pw = v; e4_enter = 1'b1; end
    else begin pw = v; enter = 1'b1; end
    @(negedge clk);
    if (sel) e4_enter = 1'b0; else enter = 1'b0;
    @(negedge clk);
  endtask

  task automatic confirm(input logic [3:0] v, output int lat);
    @(negedge clk);
    pw = v;
    enter = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      enter = 1'b0;
      if (enrolled || rejected) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_enroll(input logic [3:0] v);
    int lat, exp_lat, j;
    j = -1;
    foreach (tbl[k]) if (tbl[k] == v && j < 0) j = k;
    if (j >= 0) begin
      exp_ev_q.push_back(2'b10);
      exp_lat = 2 * j + 3;
    end else begin
      exp_ev_q.push_back(2'b01);
      exp_wr_q.push_back({5'(tbl.size()), v});
      exp_lat = 2 * tbl.size() + 2;
      tbl.push_back(v);
    end
    press(1'b0, v);
    confirm(v, lat);
    n_checks++;
    if (lat !== exp_lat) $display("FAIL latency pw=%h got %0d required %0d", v, lat, exp_lat);
    else n_pass++;
    settle(2);
    n_checks++;
    if (count !== 6'(tbl.size())) $display("FAIL count got %0d required %0d", count, tbl.size());
    else n_pass++;
    n_checks++;
    if (exp_ev_q.size() !== 0 || exp_wr_q.size() !== 0)
      $display("FAIL pending got ev=%0d wr=%0d required 0 0", exp_ev_q.size(), exp_wr_q.size());
    else n_pass++;
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1; enter = 0; pw = 0; login = 0; e4_enter = 0; e4_pw = 0; e4_login = 0;
    settle(3);
    n_checks++;
    if ({wr_en, busy, full, enrolled, rejected, count, rd_addr, wr_addr, wr_data} !== '0 || dbg !== IDLE)
      $display("FAIL reset_outputs got count=%0d busy=%0b state=%0d required all 0 IDLE", count, busy, dbg);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    settle(2);
    n_checks++;
    if (count !== 6'd0 || busy !== 1'b0 || dbg !== IDLE)
      $display("FAIL after_reset got count=%0d busy=%0b required 0 0", count, busy);
    else n_pass++;
  endtask

  task automatic test_first_enroll;
    login = 1'b1;
    do_enroll(4'hA);
    do_enroll(4'h3);
  endtask

  task automatic test_duplicate;
    rd_log.delete();
    do_enroll(4'h3);
    n_checks++;
    if (rd_log.size() !== 2 || rd_log[0] !== 5'd0 || rd_log[1] !== 5'd1)
      $display("FAIL scan_reads got n=%0d required reads 0,1", rd_log.size());
    else n_pass++;
  endtask

  task automatic test_mismatch;
    press(1'b0, 4'h5);
    exp_ev_q.push_back(2'b10);
    press(1'b0, 4'h6);
    settle(3);
    n_checks++;
    if (dbg !== IDLE || exp_ev_q.size() !== 0 || count !== 6'(tbl.size()))
      $display("FAIL mismatch got state=%0d pending=%0d required IDLE 0", dbg, exp_ev_q.size());
    else n_pass++;
  endtask

  task automatic test_not_logged_in;
    login = 1'b0;
    busy_seen = 0;
    exp_ev_q.push_back(2'b10);
    press(1'b0, 4'h7);
    settle(3);
    n_checks++;
    if (busy_seen !== 1'b0 || exp_ev_q.size() !== 0)
      $display("FAIL not_logged_in got busy_seen=%0b pending=%0d required 0 0", busy_seen, exp_ev_q.size());
    else n_pass++;
    login = 1'b1;
    press(1'b0, 4'h8);
    exp_ev_q.push_back(2'b10);
    @(negedge clk) login = 1'b0;
    settle(3);
    login = 1'b1;
    n_checks++;
    if (dbg !== IDLE || exp_ev_q.size() !== 0)
      $display("FAIL logout_wait got state=%0d pending=%0d required IDLE 0", dbg, exp_ev_q.size());
    else n_pass++;
  endtask

  task automatic test_ignored_edge;
    logic [3:0] v;
    v = 4'hE;
    exp_ev_q.push_back(2'b01);
    exp_wr_q.push_back({5'(tbl.size()), v});
    tbl.push_back(v);
    press(1'b0, v);
    @(negedge clk) begin pw = v; enter = 1'b1; end
    @(negedge clk) enter = 1'b0;
    @(negedge clk) enter = 1'b1;
    @(negedge clk) enter = 1'b0;
    settle(2 * tbl.size() + 6);
    n_checks++;
    if (dbg !== IDLE || count !== 6'(tbl.size()) || exp_ev_q.size() !== 0)
      $display("FAIL ignored_edge got state=%0d count=%0d required IDLE %0d", dbg, count, tbl.size());
    else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) do_enroll(4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_scan;
    bit hit;
    hit = 0;
    press(1'b0, 4'h1);
    @(negedge clk) begin pw = 4'h1; enter = 1'b1; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enter = 1'b0;
      if (dbg == SCAN_CHK) begin hit = 1; break; end
    end
    n_checks++;
    if (!hit) $display("FAIL reach_scan_chk got no SCAN_CHK required SCAN_CHK within 10 cycles");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_en, busy, full, enrolled, rejected, count, rd_addr, wr_addr, wr_data} !== '0 || dbg !== IDLE)
      $display("FAIL async_reset got count=%0d busy=%0b state=%0d required all 0 IDLE", count, busy, dbg);
    else n_pass++;
    tbl.delete();
    @(negedge clk) rst = 1'b0;
    settle(10);
    do_enroll(4'hC);
  endtask

  task automatic test_full;
    e4_login = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      press(1'b1, 4'(v));
      press(1'b1, 4'(v));
      settle(2 * v + 4);
      n_checks++;
      if (count4 !== 3'(v)) $display("FAIL fill_count got %0d required %0d", count4, v);
      else n_pass++;
    end
    n_checks++;
    if (full4 !== 1'b1 || n_enr4 !== 4 || mem4[0] !== 4'h1 || mem4[3] !== 4'h4)
      $display("FAIL full got full=%0b enr=%0d required 1 4", full4, n_enr4);
    else n_pass++;
    busy4_seen = 0;
    press(1'b1, 4'h5);
    settle(3);
    n_checks++;
    if (n_rej4 !== 1 || n_wr4 !== 4 || count4 !== 3'd4 || busy4_seen !== 1'b0 || dbg4 !== IDLE)
      $display("FAIL full_reject got rej=%0d wr=%0d count=%0d busy=%0b required 1 4 4 0",
               n_rej4, n_wr4, count4, busy4_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_enroll();
    test_duplicate();
    test_mismatch();
    test_not_logged_in();
    test_ignored_edge();
    test_random();
    test_reset_scan();
    test_full();
    settle(4);
    n_checks++;
    if (exp_ev_q.size() !== 0 || exp_wr_q.size() !== 0)
      $display("FAIL final_pending got ev=%0d wr=%0d required 0 0", exp_ev_q.size(), exp_wr_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
